// File: rtl/eth_hdr_writer.sv
// eth_hdr_writer: rewrites dmac/smac/ethertype/dst-port of each packet's first word
// from a small first-word-fall-through metadata FIFO; all other words pass through.
module eth_hdr_writer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int MAC_WIDTH            = 48,
    parameter int META_DEPTH_BITS      = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_S_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic [MAC_WIDTH-1:0]              i_mac0,
    input  logic [MAC_WIDTH-1:0]              i_mac1,
    input  logic [MAC_WIDTH-1:0]              i_mac2,
    input  logic [MAC_WIDTH-1:0]              i_mac3,
    input  logic                              i_meta_wr_en,
    input  logic                              i_meta_rewrite,
    input  logic [MAC_WIDTH-1:0]              i_meta_dmac,
    input  logic [15:0]                       i_meta_ethertype,
    input  logic [7:0]                        i_meta_dport,
    output logic                              o_meta_full,
    output logic                              o_meta_overflow,
    output logic [31:0]                       o_pkt_cnt
);
    localparam int DEPTH = 1 << META_DEPTH_BITS;
    localparam int MW    = 1 + MAC_WIDTH + 16 + 8;
    localparam int CW    = META_DEPTH_BITS + 1;

    typedef enum logic {HDR, BODY} state_t;

    state_t                     state_q;
    logic [MW-1:0]              mem_q [DEPTH];
    logic [META_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       overflow_q;
    logic [31:0]                pkt_cnt_q;

    logic                       empty, is_hdr, gate, hs, push, pop, rw;
    logic                       h_rw;
    logic [MAC_WIDTH-1:0]       h_dmac, smac;
    logic [15:0]                h_type;
    logic [7:0]                 h_dport, sel;

    assign {h_rw, h_dmac, h_type, h_dport} = mem_q[rd_ptr_q];

    assign empty         = cnt_q == '0;
    assign o_meta_full   = cnt_q == CW'(DEPTH);
    assign is_hdr        = state_q == HDR;
    // A header beat may only move once its metadata is at the FIFO head.
    assign gate          = !is_hdr || !empty;
    assign s_axis_tready = m_axis_tready && gate;
    assign m_axis_tvalid = s_axis_tvalid && gate;
    assign hs            = s_axis_tvalid && s_axis_tready;
    assign pop           = hs && s_axis_tlast;
    assign push          = i_meta_wr_en && !o_meta_full;
    assign rw            = is_hdr && !empty && h_rw;
    assign cnt_d         = cnt_q + CW'(push) - CW'(pop);

    assign sel  = h_dport & 8'h55;
    assign smac = sel == 8'h01 ? i_mac0 :
                  sel == 8'h04 ? i_mac1 :
                  sel == 8'h10 ? i_mac2 :
                  sel == 8'h40 ? i_mac3 : s_axis_tdata[207:160];

    assign m_axis_tdata = rw ? {h_dmac, smac, h_type, s_axis_tdata[143:0]} : s_axis_tdata;
    assign m_axis_tuser = rw ? {s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:32], h_dport, s_axis_tuser[23:0]}
                             : s_axis_tuser;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;

    assign o_meta_overflow = overflow_q;
    assign o_pkt_cnt       = pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {i_meta_rewrite, i_meta_dmac, i_meta_ethertype, i_meta_dport};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
            if (i_meta_wr_en && o_meta_full)
                overflow_q <= 1'b1;
            if (hs && rw)
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (hs)
                state_q <= s_axis_tlast ? HDR : BODY;
        end
    end
endmodule

// File: tb/tb_eth_hdr_writer.sv
// tb_eth_hdr_writer: directed and randomized stimulus checked every cycle against a
// queue-based packet/metadata model, plus literal expectations from hand-worked cases.
module tb_eth_hdr_writer;
    typedef struct packed {
        logic        rw;
        logic [47:0] dmac;
        logic [15:0] et;
        logic [7:0]  dp;
    } meta_t;

    logic         clk = 0, reset = 1;
    logic [255:0] s_axis_tdata = '0, m_axis_tdata;
    logic [31:0]  s_axis_tkeep = '0, m_axis_tkeep;
    logic [127:0] s_axis_tuser = '0, m_axis_tuser;
    logic         s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
    logic         m_axis_tvalid, m_axis_tready = 1, m_axis_tlast;
    logic [47:0]  i_mac0 = 48'hA00000000000, i_mac1 = 48'h001122334455;
    logic [47:0]  i_mac2 = 48'hA20000000002, i_mac3 = 48'hA30000000003;
    logic         i_meta_wr_en = 0, i_meta_rewrite = 0;
    logic [47:0]  i_meta_dmac = '0;
    logic [15:0]  i_meta_ethertype = '0;
    logic [7:0]   i_meta_dport = '0;
    logic         o_meta_full, o_meta_overflow;
    logic [31:0]  o_pkt_cnt;

    eth_hdr_writer dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .i_mac0(i_mac0), .i_mac1(i_mac1), .i_mac2(i_mac2), .i_mac3(i_mac3),
        .i_meta_wr_en(i_meta_wr_en), .i_meta_rewrite(i_meta_rewrite), .i_meta_dmac(i_meta_dmac),
        .i_meta_ethertype(i_meta_ethertype), .i_meta_dport(i_meta_dport),
        .o_meta_full(o_meta_full), .o_meta_overflow(o_meta_overflow), .o_pkt_cnt(o_pkt_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0, fails = 0;

    function automatic void chk(string n, logic [255:0] a, logic [255:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", n, a, e);
        end
    endfunction

    // Reference model: metadata queue, header/body flag, counters.
    meta_t        mq[$];
    bit           m_hdr = 1, m_ovf = 0, p_stall = 0, p_l;
    int unsigned  m_cnt = 0;
    logic [255:0] ed, p_d;
    logic [127:0] eu, p_u;
    bit           ok, etv, hs, was_full;

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_hdr = 1; m_cnt = 0; m_ovf = 0; p_stall = 0;
        end else begin
            ok  = !m_hdr || mq.size() != 0;
            etv = s_axis_tvalid && ok;
            chk("s_tready", s_axis_tready, m_axis_tready && ok);
            chk("m_tvalid", m_axis_tvalid, etv);
            chk("meta_full", o_meta_full, mq.size() == 4);
            chk("meta_ovf", o_meta_overflow, m_ovf);
            chk("pkt_cnt", o_pkt_cnt, m_cnt);
            if (p_stall) begin
                chk("hold_data", m_axis_tdata, p_d);
                chk("hold_user", m_axis_tuser, p_u);
                chk("hold_last", m_axis_tlast, p_l);
            end
            ed = s_axis_tdata;
            eu = s_axis_tuser;
            if (m_hdr && ok && mq[0].rw) begin
                ed[255:208] = mq[0].dmac;
                ed[159:144] = mq[0].et;
                eu[31:24]   = mq[0].dp;
                case (mq[0].dp & 8'h55)
                    8'h01: ed[207:160] = i_mac0;
                    8'h04: ed[207:160] = i_mac1;
                    8'h10: ed[207:160] = i_mac2;
                    8'h40: ed[207:160] = i_mac3;
                    default: ;
                endcase
            end
            if (etv) begin
                chk("m_tdata", m_axis_tdata, ed);
                chk("m_tuser", m_axis_tuser, eu);
                chk("m_tkeep", m_axis_tkeep, s_axis_tkeep);
                chk("m_tlast", m_axis_tlast, s_axis_tlast);
            end
            p_stall = etv && !m_axis_tready;
            p_d = ed; p_u = eu; p_l = s_axis_tlast;
            hs = etv && m_axis_tready;
            was_full = mq.size() == 4;
            if (hs && m_hdr && mq[0].rw) m_cnt++;
            if (hs && s_axis_tlast) void'(mq.pop_front());
            if (hs) m_hdr = s_axis_tlast;
            if (i_meta_wr_en) begin
                if (was_full) m_ovf = 1;
                else mq.push_back({i_meta_rewrite, i_meta_dmac, i_meta_ethertype, i_meta_dport});
            end
        end
    end

    int  rdy_mode = 0;
    bit  rand_push = 0;

    always @(posedge clk) begin
        #1;
        m_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : ~m_axis_tready;
        if (rand_push) begin
            i_meta_wr_en     = ($urandom % 4) == 0;
            i_meta_rewrite   = 1'($urandom % 4 != 0);
            i_meta_dmac      = {16'($urandom), 32'($urandom)};
            i_meta_ethertype = 16'($urandom);
            case ($urandom % 6)
                0: i_meta_dport = 8'h01;
                1: i_meta_dport = 8'h04;
                2: i_meta_dport = 8'h10;
                3: i_meta_dport = 8'h40;
                default: i_meta_dport = 8'($urandom);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_meta(logic rw, logic [47:0] dm, logic [15:0] et, logic [7:0] dp);
        i_meta_wr_en = 1; i_meta_rewrite = rw; i_meta_dmac = dm;
        i_meta_ethertype = et; i_meta_dport = dp;
        tick();
        i_meta_wr_en = 0;
    endtask

    logic [255:0] cap_d, in_d;
    logic [127:0] cap_u, in_u;
    int           waits;

    task automatic send_word(logic [255:0] d, logic [127:0] u, logic last);
        bit got = 0;
        s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = last;
        s_axis_tkeep = last ? 32'($urandom) : '1;
        s_axis_tvalid = 1;
        waits = 0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            got = s_axis_tready;
            cap_d = m_axis_tdata; cap_u = m_axis_tuser;
            waits++;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 0;
        if (!got) begin
            fails++;
            $display("FAIL send_timeout: actual=no handshake required=handshake");
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic new_word();
        in_d = rnd256();
        in_u = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 0;
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_pkt_cnt", o_pkt_cnt, 0);
        chk("rst_full", o_meta_full, 0);
        chk("rst_ovf", o_meta_overflow, 0);

        // Basic 3-word rewrite.
        push_meta(1, 48'h0A0B0C0D0E0F, 16'h0800, 8'h04);
        new_word();
        send_word(in_d, in_u, 0);
        chk("t1_dmac", cap_d[255:208], 48'h0A0B0C0D0E0F);
        chk("t1_smac", cap_d[207:160], 48'h001122334455);
        chk("t1_etype", cap_d[159:144], 16'h0800);
        chk("t1_dport", cap_u[31:24], 8'h04);
        chk("t1_rest", cap_d[143:0], in_d[143:0]);
        for (int w = 1; w < 3; w++) begin
            new_word();
            send_word(in_d, in_u, w == 2);
            chk("t1_body_d", cap_d, in_d);
            chk("t1_body_u", cap_u, in_u);
        end
        chk("t1_cnt", o_pkt_cnt, 1);

        // Packet waits for metadata, then moves the cycle the entry becomes visible.
        new_word();
        s_axis_tdata = in_d; s_axis_tuser = in_u; s_axis_tlast = 1; s_axis_tvalid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("t2_tready0", s_axis_tready, 0);
            chk("t2_tvalid0", m_axis_tvalid, 0);
            tick();
        end
        push_meta(1, 48'h111111111111, 16'h86DD, 8'h01);
        send_word(in_d, in_u, 1);
        chk("t2_latency", waits, 1);
        chk("t2_smac", cap_d[207:160], 48'hA00000000000);

        // rewrite=0: untouched, counter unchanged.
        push_meta(0, 48'h222222222222, 16'h1234, 8'h02);
        new_word();
        send_word(in_d, in_u, 0);
        chk("t3_data", cap_d, in_d);
        chk("t3_user", cap_u, in_u);
        new_word();
        send_word(in_d, in_u, 1);
        chk("t3_cnt", o_pkt_cnt, 2);

        // Back-to-back single-word packets under toggling ready.
        for (int i = 0; i < 4; i++) push_meta(1, 48'h100 + 48'(i), 16'h0800, 8'h10);
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            new_word();
            send_word(in_d, in_u, 1);
            chk("t4_order", cap_d[255:208], 48'h100 + 48'(i));
        end
        rdy_mode = 0;
        tick();

        // Fill, overflow, then drain in order.
        for (int i = 0; i < 5; i++) begin
            push_meta(1, 48'h200 + 48'(i), 16'h0806, 8'h40);
            if (i == 3) chk("t5_full", o_meta_full, 1);
        end
        chk("t5_ovf", o_meta_overflow, 1);
        for (int i = 0; i < 4; i++) begin
            new_word();
            send_word(in_d, in_u, 1);
            chk("t5_dmac", cap_d[255:208], 48'h200 + 48'(i));
        end
        chk("t5_cnt", o_pkt_cnt, 10);

        // Reset in the middle of a 4-word packet.
        push_meta(1, 48'h333333333333, 16'h0800, 8'h04);
        push_meta(1, 48'h444444444444, 16'h0800, 8'h04);
        for (int w = 0; w < 2; w++) begin
            new_word();
            send_word(in_d, in_u, 0);
        end
        new_word();
        s_axis_tdata = in_d; s_axis_tvalid = 1; s_axis_tlast = 0;
        reset = 1;
        tick();
        reset = 0; s_axis_tvalid = 0;
        chk("t6_cnt", o_pkt_cnt, 0);
        chk("t6_full", o_meta_full, 0);
        chk("t6_ovf", o_meta_overflow, 0);
        s_axis_tvalid = 1;
        @(negedge clk);
        chk("t6_empty", s_axis_tready, 0);
        tick();
        s_axis_tvalid = 0;
        push_meta(1, 48'h555555555555, 16'h0800, 8'h01);
        new_word();
        send_word(in_d, in_u, 0);
        chk("t6_dmac", cap_d[255:208], 48'h555555555555);
        new_word();
        send_word(in_d, in_u, 1);
        chk("t6_cnt1", o_pkt_cnt, 1);

        // Randomized traffic.
        rdy_mode = 1;
        rand_push = 1;
        for (int p = 0; p < 60; p++) begin
            int len = 1 + $urandom % 4;
            for (int w = 0; w < len; w++) begin
                new_word();
                send_word(in_d, in_u, w == len - 1);
            end
        end
        rand_push = 0;
        i_meta_wr_en = 0;
        rdy_mode = 0;
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
